// File: rtl/camera_frontend.sv
`default_nettype none
// ============================================================================
// Module   : camera_frontend
// Brief    : Camera bus synchroniser, pixel strobe generator, partial-frame
//            gate and line/frame geometry monitor.
//            Optional: CAMERA_FRONTEND_TEST_PATTERN_EN adds test_pattern input.
// Revision : 1.0
// ============================================================================
module camera_frontend #(
  parameter int SYNC_STAGES    = 2,
  parameter int LINE_PIXELS    = 320,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cam_pclk,
  input  logic [11:0] cam_data,
  input  logic        cam_lval,
  input  logic        cam_fval,
`ifdef CAMERA_FRONTEND_TEST_PATTERN_EN
  input  logic        test_pattern,
`endif
  output logic [11:0] vid_pixel,
  output logic        vid_pixsync,
  output logic        vid_hblank,
  output logic        vid_vblank,
  output logic        vid_visible,
  output logic [15:0] stat_frame_count,
  output logic [9:0]  stat_line_count,
  output logic        stat_line_err,
  input  logic        stat_err_clear,
  output logic        stat_signal_lost
);

  localparam int              TO_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_SAT   = TO_W'(TIMEOUT_CYCLES);
  localparam logic [8:0]      LINE_LEN = 9'(LINE_PIXELS);

  typedef enum logic [1:0] {
    ST_WAIT_IDLE = 2'd0,
    ST_VBLANK    = 2'd1,
    ST_ACTIVE    = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] pclk_sync_q;
  logic [SYNC_STAGES-1:0] lval_sync_q;
  logic [SYNC_STAGES-1:0] fval_sync_q;
  logic [11:0]            data_sync_q [SYNC_STAGES];
  logic                   pclk_prev_q;
  logic                   pclk_rise;

  logic                   ev_q;
  logic [11:0]            ev_data_q;
  logic                   ev_lval_q;
  logic                   ev_fval_q;

  logic [TO_W-1:0]        to_cnt_q;
  logic                   timeout_hit;

  state_t                 state_q;
  logic [11:0]            vid_pixel_q;
  logic                   vid_pixsync_q;
  logic                   vid_hblank_q;
  logic                   vid_vblank_q;
  logic                   vid_visible_q;
  logic [15:0]            frame_cnt_q;
  logic [9:0]             line_stat_q;
  logic                   line_err_q;
  logic                   lost_q;
  logic [8:0]             xcount_q;
  logic [9:0]             line_cnt_q;
  logic                   prev_lval_q;

  logic                   line_end;
  logic                   line_err_set;
  logic [8:0]             x_inc;
  logic [9:0]             line_inc;
  logic [11:0]            pixel_d;

  // Identical-depth chains keep data/lval/fval aligned with the pclk edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pclk_sync_q <= '0;
      lval_sync_q <= '0;
      fval_sync_q <= '0;
      pclk_prev_q <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) data_sync_q[i] <= '0;
    end else begin
      pclk_sync_q    <= {pclk_sync_q[SYNC_STAGES-2:0], cam_pclk};
      lval_sync_q    <= {lval_sync_q[SYNC_STAGES-2:0], cam_lval};
      fval_sync_q    <= {fval_sync_q[SYNC_STAGES-2:0], cam_fval};
      pclk_prev_q    <= pclk_sync_q[SYNC_STAGES-1];
      data_sync_q[0] <= cam_data;
      for (int i = 1; i < SYNC_STAGES; i++) data_sync_q[i] <= data_sync_q[i-1];
    end
  end

  assign pclk_rise = pclk_sync_q[SYNC_STAGES-1] & ~pclk_prev_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ev_q      <= 1'b0;
      ev_data_q <= '0;
      ev_lval_q <= 1'b0;
      ev_fval_q <= 1'b0;
    end else begin
      ev_q <= pclk_rise;
      if (pclk_rise) begin
        ev_data_q <= data_sync_q[SYNC_STAGES-1];
        ev_lval_q <= lval_sync_q[SYNC_STAGES-1];
        ev_fval_q <= fval_sync_q[SYNC_STAGES-1];
      end
    end
  end

  // Saturates one past the trigger value so the timeout fires only once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt_q <= '0;
    end else if (pclk_rise) begin
      to_cnt_q <= '0;
    end else if (to_cnt_q != TO_SAT) begin
      to_cnt_q <= to_cnt_q + 1'b1;
    end
  end

  assign timeout_hit = ~pclk_rise & (to_cnt_q == TO_LAST);

  always_comb begin
    line_end     = ev_q & prev_lval_q & ~ev_lval_q & (state_q != ST_WAIT_IDLE);
    line_err_set = line_end & (xcount_q != LINE_LEN);
    x_inc        = (xcount_q == 9'd511) ? xcount_q : xcount_q + 9'd1;
    line_inc     = (line_cnt_q == 10'd1023) ? line_cnt_q : line_cnt_q + 10'd1;
    pixel_d      = ev_data_q;
`ifdef CAMERA_FRONTEND_TEST_PATTERN_EN
    if (test_pattern && ev_lval_q && ev_fval_q && (state_q != ST_WAIT_IDLE)) begin
      pixel_d = (state_q == ST_VBLANK) ? 12'd0 : {xcount_q[7:0], 4'b0000};
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_WAIT_IDLE;
      vid_pixel_q   <= '0;
      vid_pixsync_q <= 1'b0;
      vid_hblank_q  <= 1'b1;
      vid_vblank_q  <= 1'b1;
      vid_visible_q <= 1'b0;
      frame_cnt_q   <= '0;
      line_stat_q   <= '0;
      lost_q        <= 1'b0;
      xcount_q      <= '0;
      line_cnt_q    <= '0;
      prev_lval_q   <= 1'b0;
    end else begin
      vid_pixsync_q <= 1'b0;
      if (timeout_hit) begin
        lost_q        <= 1'b1;
        state_q       <= ST_WAIT_IDLE;
        vid_hblank_q  <= 1'b1;
        vid_vblank_q  <= 1'b1;
        vid_visible_q <= 1'b0;
      end else if (ev_q) begin
        lost_q        <= 1'b0;
        vid_pixsync_q <= 1'b1;
        vid_pixel_q   <= pixel_d;
        prev_lval_q   <= ev_lval_q;
        if (state_q != ST_WAIT_IDLE) begin
          if (line_end) begin
            xcount_q   <= '0;
            line_cnt_q <= line_inc;
          end else if (ev_lval_q && ev_fval_q) begin
            xcount_q <= x_inc;
          end
        end
        case (state_q)
          ST_WAIT_IDLE: begin
            vid_hblank_q  <= 1'b1;
            vid_vblank_q  <= 1'b1;
            vid_visible_q <= 1'b0;
            if (!ev_fval_q) state_q <= ST_VBLANK;
          end
          ST_VBLANK: begin
            if (ev_fval_q) begin
              vid_hblank_q  <= ~ev_lval_q;
              vid_vblank_q  <= 1'b0;
              vid_visible_q <= ev_lval_q;
              line_cnt_q    <= '0;
              xcount_q      <= {8'd0, ev_lval_q};
              state_q       <= ST_ACTIVE;
            end else begin
              vid_hblank_q  <= 1'b1;
              vid_vblank_q  <= 1'b1;
              vid_visible_q <= 1'b0;
            end
          end
          ST_ACTIVE: begin
            vid_hblank_q  <= ~ev_lval_q;
            vid_vblank_q  <= ~ev_fval_q;
            vid_visible_q <= ev_lval_q & ev_fval_q;
            if (!ev_fval_q) begin
              // A line closing on the frame-ending edge still counts.
              frame_cnt_q <= frame_cnt_q + 16'd1;
              line_stat_q <= line_end ? line_inc : line_cnt_q;
              state_q     <= ST_VBLANK;
            end
          end
          default: state_q <= ST_WAIT_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      line_err_q <= 1'b0;
    end else if (line_err_set) begin
      line_err_q <= 1'b1;
    end else if (stat_err_clear) begin
      line_err_q <= 1'b0;
    end
  end

  assign vid_pixel        = vid_pixel_q;
  assign vid_pixsync      = vid_pixsync_q;
  assign vid_hblank       = vid_hblank_q;
  assign vid_vblank       = vid_vblank_q;
  assign vid_visible      = vid_visible_q;
  assign stat_frame_count = frame_cnt_q;
  assign stat_line_count  = line_stat_q;
  assign stat_line_err    = line_err_q;
  assign stat_signal_lost = lost_q;

endmodule
`default_nettype wire
